// File: rtl/sb_initiator_if.sv
// sb_initiator port bundle: command/response side
// plus the iCE40UP hard-IP system-bus register port.
interface sb_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       sb_stb_o;
  logic       sb_rw_o;
  logic [7:0] sb_adr_o;
  logic [7:0] sb_dat_o;
  logic [7:0] sb_dat_i;
  logic       sb_ack_i;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output sb_dat_i, sb_ack_i,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  sb_stb_o, sb_rw_o, sb_adr_o, sb_dat_o
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  sb_dat_i, sb_ack_i,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output sb_stb_o, sb_rw_o, sb_adr_o, sb_dat_o
  );
endinterface

// File: rtl/sb_initiator.sv
// sb_initiator: one-shot register commands to
// strobe/ack cycles on the iCE40UP I2C system bus.
module sb_initiator #(
  parameter logic [3:0]  BUS_ADDR74  = 4'b0001,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sb_initiator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STB  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam int unsigned TO_LAST_I =
    TO_EN ? TIMEOUT_CYC - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_LAST_I[TO_W-1:0];
  localparam logic [7:0] ADR_RST = {BUS_ADDR74, 4'h0};

  state_t          state_q;
  logic [TO_W-1:0] to_q;
  logic            rdy_q;
  logic            stb_q;
  logic            rw_q;
  logic [7:0]      adr_q;
  logic [7:0]      dat_q;
  logic            rvld_q;
  logic            rerr_q;
  logic [7:0]      rdata_q;

  // Bus-cycle FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      to_q    <= '0;
      rdy_q   <= 1'b1;
      stb_q   <= 1'b0;
      rw_q    <= 1'b0;
      adr_q   <= ADR_RST;
      dat_q   <= 8'h00;
      rvld_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          rvld_q <= 1'b0;
          if (bus.cmd_valid && rdy_q) begin
            rw_q    <= bus.cmd_we;
            adr_q   <= {BUS_ADDR74, bus.cmd_addr};
            dat_q   <= bus.cmd_wdata;
            stb_q   <= 1'b1;
            to_q    <= '0;
            rdy_q   <= 1'b0;
            state_q <= STB;
          end
        end
        STB: begin
          if (bus.sb_ack_i) begin
            if (!rw_q) rdata_q <= bus.sb_dat_i;
            rerr_q  <= 1'b0;
            stb_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RSP;
          end else if (TO_EN && to_q == TO_LAST) begin
            rerr_q  <= 1'b1;
            rdata_q <= 8'h00;
            stb_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RSP;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        RSP: begin
          rvld_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          stb_q   <= 1'b0;
          rvld_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.sb_stb_o  = stb_q;
  assign bus.sb_rw_o   = rw_q;
  assign bus.sb_adr_o  = adr_q;
  assign bus.sb_dat_o  = dat_q;

endmodule

// File: tb/tb_sb_initiator.sv
// Testbench for sb_initiator: vector table plus
// hand sequences, responses checked via a queue.
module tb_sb_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sb_initiator_if bus ();

  sb_initiator #(
    .BUS_ADDR74 (4'h1),
    .TIMEOUT_CYC(4),
    .TO_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         ack_at;
    logic [7:0] ip_data;
    int         exp_stb;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  vec_t vecs[7];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 16'd1, 16'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", 16'(bus.rsp_err), 16'(e.err));
        chk("rsp_rdata", 16'(bus.rsp_rdata), 16'(e.rdata));
      end
    end
  end

  task automatic run(input vec_t v);
    int   n;
    rsp_t e;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = v.we;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 16'(bus.cmd_ready), 16'd1);
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~v.we;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    n = 0;
    @(negedge clk);
    while (bus.sb_stb_o && n < 20) begin
      n++;
      chk("sb_adr", 16'(bus.sb_adr_o), 16'({4'h1, v.addr}));
      chk("sb_rw", 16'(bus.sb_rw_o), 16'(v.we));
      if (v.we) chk("sb_dat", 16'(bus.sb_dat_o), 16'(v.wdata));
      chk("ready_in_stb", 16'(bus.cmd_ready), 16'd0);
      if (n == v.ack_at) begin
        bus.sb_ack_i = 1'b1;
        bus.sb_dat_i = v.ip_data;
      end else begin
        bus.sb_ack_i = 1'b0;
        bus.sb_dat_i = 8'hEE;
      end
      @(negedge clk);
    end
    bus.sb_ack_i = 1'b0;
    chk("stb_cycles", 16'(n), 16'(v.exp_stb));
    chk("rsp_valid_at", 16'(bus.rsp_valid), 16'd1);
    chk("ready_in_rsp", 16'(bus.cmd_ready), 16'd0);
    @(negedge clk);
    chk("rsp_pulse_end", 16'(bus.rsp_valid), 16'd0);
    chk("ready_again", 16'(bus.cmd_ready), 16'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_stb"}, 16'(bus.sb_stb_o), 16'd0);
    chk({nm, "_rw"}, 16'(bus.sb_rw_o), 16'd0);
    chk({nm, "_adr"}, 16'(bus.sb_adr_o), 16'h10);
    chk({nm, "_dat"}, 16'(bus.sb_dat_o), 16'd0);
    chk({nm, "_rv"}, 16'(bus.rsp_valid), 16'd0);
    chk({nm, "_err"}, 16'(bus.rsp_err), 16'd0);
    chk({nm, "_rdata"}, 16'(bus.rsp_rdata), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rdy_pat;
    logic [8:0] stb_pat;
    logic [8:0] rv_pat;
    rsp_t e;
    int   n;

    vecs[0] = '{1'b1, 4'h8, 8'hA5, 2, 8'h5A, 2, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 4'hE, 8'h00, 1, 8'h3C, 1, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 4'h3, 8'h00, 0, 8'h00, 4, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 4'h5, 8'h00, 4, 8'h77, 4, 1'b0, 8'h77};
    vecs[4] = '{1'b1, 4'h2, 8'h11, 1, 8'h99, 1, 1'b0, 8'h77};
    vecs[5] = '{1'b0, 4'hF, 8'h00, 3, 8'hC3, 3, 1'b0, 8'hC3};
    vecs[6] = '{1'b1, 4'h0, 8'hFF, 0, 8'h00, 4, 1'b1, 8'h00};

    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 4'h0;
    bus.cmd_wdata = 8'h00;
    bus.sb_dat_i  = 8'h00;
    bus.sb_ack_i  = 1'b0;

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 16'(bus.cmd_ready), 16'd1);

    // Stray ack while idle must do nothing.
    bus.sb_ack_i = 1'b1;
    bus.sb_dat_i = 8'h66;
    repeat (3) @(negedge clk);
    chk("stray_stb", 16'(bus.sb_stb_o), 16'd0);
    chk("stray_rv", 16'(bus.rsp_valid), 16'd0);
    chk("stray_rdy", 16'(bus.cmd_ready), 16'd1);
    bus.sb_ack_i = 1'b0;

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Back-to-back reads with ack held high throughout.
    rdy_pat = 9'b001001001;
    stb_pat = 9'b010010010;
    rv_pat  = 9'b100100100;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 4'h1;
    bus.sb_ack_i  = 1'b1;
    bus.sb_dat_i  = 8'h42;
    e.err   = 1'b0;
    e.rdata = 8'h42;
    repeat (3) exp_q.push_back(e);
    for (int i = 0; i < 9; i++) begin
      chk("b2b_rdy", 16'(bus.cmd_ready), 16'(rdy_pat[i]));
      chk("b2b_stb", 16'(bus.sb_stb_o), 16'(stb_pat[i]));
      chk("b2b_rv", 16'(bus.rsp_valid), 16'(rv_pat[i]));
      if (i < 8) @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.sb_ack_i  = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 16'(bus.cmd_ready), 16'd1);

    // Reset in the middle of a strobe: command is lost.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 4'h7;
    bus.cmd_wdata = 8'h5C;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_stb_up", 16'(bus.sb_stb_o), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.sb_stb_o) n++;
    end
    chk("midrst_quiet", 16'(n), 16'd0);
    chk("midrst_rdy", 16'(bus.cmd_ready), 16'd1);
    run(vecs[1]);

    repeat (2) @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sb_initiator.md
Name: sb_initiator

Overview:
- System-bus initiator that drives the register port of the iCE40UP hard I2C block (SBSTBI/SBRWI/SBADRI/SBDATI in, SBDATO/SBACKO out).
- Turns simple one-shot register read/write commands from fabric logic (I2C driver FSM or soft CPU bridge) into strobe/acknowledge bus cycles.
- Captures read data, reports completion, and aborts hung cycles with a timeout.
- Sits between the I2C control logic and the I2C_B wrapper, in the same SBCLKI domain.

Parameters:
- BUS_ADDR74, 4'b0001, upper address nibble driven on sb_adr_o[7:4]; must match the target IP's BUS_ADDR74.
- TIMEOUT_CYC, 255, max cycles the strobe stays high without ack before abort; 0 disables timeout; legal range 0..65535.
- TO_W, 16, timeout counter width; must satisfy TO_W >= clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system-bus clock, same net as the IP's SBCLKI.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; the command is accepted on cmd_valid&&cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  4  register offset, driven on sb_adr_o[3:0].
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = timed out.
- rsp_rdata  out  8  read data, valid with rsp_valid; held until the next rsp_valid.
- sb_stb_o  out  1  to SBSTBI.
- sb_rw_o  out  1  to SBRWI; 1 = write.
- sb_adr_o  out  8  to SBADRI7..0.
- sb_dat_o  out  8  to SBDATI7..0.
- sb_dat_i  in  8  from SBDATO7..0.
- sb_ack_i  in  1  from SBACKO.

Behaviour:
- Reset values (all outputs registered; reset is async assert, sync release via the existing reset synchronizer):
  - sb_stb_o=0, sb_rw_o=0, sb_adr_o={BUS_ADDR74,4'h0}, sb_dat_o=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=1 once reset deasserts.
- FSM states: IDLE, STB, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch we/addr/wdata into sb_rw_o/sb_adr_o/sb_dat_o, set sb_stb_o=1, clear timeout counter, go to STB.
  - sb_stb_o rises the cycle after accept (latency 1).
- STB:
  - sb_stb_o=1; sb_rw_o, sb_adr_o and sb_dat_o held stable for the whole cycle.
  - Counter increments each cycle sb_ack_i=0.
  - If sb_ack_i=1: capture rsp_rdata<=sb_dat_i on reads (rsp_rdata unchanged on writes), rsp_err<=0, sb_stb_o<=0, go to RSP.
  - Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: sb_stb_o<=0, rsp_err<=1, rsp_rdata<=0, go to RSP.
  - Ack and timeout in the same cycle: ack wins, rsp_err=0.
- RSP:
  - rsp_valid=1 for exactly one cycle, sb_stb_o=0, cmd_ready=0; go to IDLE.
  - This guarantees at least one strobe-low cycle between bus cycles, as the hard IP requires.
- Timing:
  - Minimum command period is 3 clocks (accept, STB with ack on its first cycle, RSP).
  - With ack after N strobe cycles, rsp_valid occurs N+1 cycles after accept.
- Error and boundary cases:
  - sb_ack_i outside STB: ignored, no state change.
  - cmd_valid while cmd_ready=0: not accepted; the requester must hold it.
  - cmd inputs may change after accept without effect.
  - Reset mid-cycle (STB or RSP): sb_stb_o drops asynchronously, no rsp_valid is generated, the command is lost.
  - TIMEOUT_CYC=0: waits for ack indefinitely.

Test Plan:
- Write: cmd_we=1, addr=4'h8, wdata=8'hA5, ack on 2nd strobe cycle -> sb_adr_o=8'h18, sb_rw_o=1, sb_dat_o=8'hA5, stb high exactly 2 cycles, rsp_valid at accept+3, rsp_err=0.
- Read: addr=4'hE, IP returns sb_dat_i=8'h3C with ack on 1st strobe cycle -> rsp_rdata=8'h3C, rsp_err=0, rsp_valid at accept+2, cmd_ready high again at accept+3.
- Timeout: TIMEOUT_CYC=4, ack never asserted -> stb high exactly 4 cycles, then rsp_valid with rsp_err=1, rsp_rdata=8'h00.
- Collision: TIMEOUT_CYC=4, ack on 4th strobe cycle -> rsp_err=0, read data captured.
- Back-to-back: cmd_valid held high for 3 commands, each acked on the first strobe cycle -> accepts every 3 cycles, sb_stb_o low at least 1 cycle between strobes, stray ack in IDLE ignored.
- Reset: rst_n=0 during STB -> sb_stb_o=0 immediately, all outputs at reset values, no rsp_valid; the next command completes normally.
